// File: rtl/tx_symbols_pkg.sv
// ---------------------------------------------------------------------------
// tx_symbols_pkg
// Shared definitions for the transmit framing path: the framing/ordered-set
// symbol values, the select codes for the 4-way transmit symbol mux, the
// framer state enum and the packet-boundary decision helper.
// ---------------------------------------------------------------------------
package tx_symbols_pkg;

   // Symbol and mux select widths
   localparam int SYM_W = 8;
   localparam int SEL_W = 2;

   // Framing and ordered-set symbols
   localparam logic [SYM_W-1:0] SYM_STP = 8'hFB;
   localparam logic [SYM_W-1:0] SYM_END = 8'hFD;
   localparam logic [SYM_W-1:0] SYM_EDB = 8'hFE;
   localparam logic [SYM_W-1:0] SYM_COM = 8'hBC;
   localparam logic [SYM_W-1:0] SYM_SKP = 8'h1C;
   localparam logic [SYM_W-1:0] SYM_IDL = 8'h7C;

   // Select codes for the downstream symbol mux
   localparam logic [SEL_W-1:0] SEL_DATA = 2'b00;
   localparam logic [SEL_W-1:0] SEL_SE   = 2'b01;
   localparam logic [SEL_W-1:0] SEL_OS   = 2'b10;
   localparam logic [SEL_W-1:0] SEL_COM  = 2'b11;

   // Framer states; every output except data_pop is a pure decode of these
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_STP     = 3'd1,
      ST_DATA    = 3'd2,
      ST_END     = 3'd3,
      ST_EDB     = 3'd4,
      ST_SKP_COM = 3'd5,
      ST_SKP     = 3'd6
   } txState_e;

   // Decision taken whenever the link sits at a packet boundary: a pending
   // SKP request always wins over a packet waiting in the buffer, so the
   // clock-compensation set is never starved by back-to-back traffic.
   function automatic txState_e boundaryNext(input logic skpPending,
                                             input logic dataAvail);
      txState_e nxt;
      if (skpPending) begin
         nxt = ST_SKP_COM;
      end else if (dataAvail) begin
         nxt = ST_STP;
      end else begin
         nxt = ST_IDLE;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/tx_framer_if.sv
// ---------------------------------------------------------------------------
// tx_framer_if
// Bundles the transmit-buffer handshake and the symbol-mux controls that the
// framer drives.
//   data_avail  : buffer head byte valid              (buffer -> framer)
//   data_last   : head byte ends the current packet   (buffer -> framer)
//   data_pop    : consume head byte this cycle        (framer -> buffer)
//   control     : mux select 00 data/01 SE/10 OS/11 COM (framer -> mux)
//   start_end   : framing character                   (framer -> mux)
//   ordered_set : ordered-set / idle symbol           (framer -> mux)
//   logical_COM : COM symbol, constant                (framer -> mux)
//   underrun    : packet ended with EDB this cycle    (framer -> status)
// Modport master is the framer side, slave is the buffer/mux side.
// ---------------------------------------------------------------------------
interface tx_framer_if;
   import tx_symbols_pkg::*;

   logic             data_avail;
   logic             data_last;
   logic             data_pop;
   logic [SEL_W-1:0] control;
   logic [SYM_W-1:0] start_end;
   logic [SYM_W-1:0] ordered_set;
   logic [SYM_W-1:0] logical_COM;
   logic             underrun;

   modport master (
      input  data_avail,
      input  data_last,
      output data_pop,
      output control,
      output start_end,
      output ordered_set,
      output logical_COM,
      output underrun
   );

   modport slave (
      output data_avail,
      output data_last,
      input  data_pop,
      input  control,
      input  start_end,
      input  ordered_set,
      input  logical_COM,
      input  underrun
   );

endinterface

// File: rtl/tx_framer_skp_timer.sv
// ---------------------------------------------------------------------------
// skp_timer
// Free-running SKP interval timer. Counts every clock regardless of traffic
// and raises skp_req once per SKP_INTERVAL cycles. The request stays high
// until the framer acknowledges it by entering its COM state.
//   clk      : transmit clock
//   reset_L  : asynchronous active-low reset
//   skp_ack  : framer is entering the SKP_COM state this cycle
//   skp_req  : an SKP ordered set is owed at the next packet boundary
// ---------------------------------------------------------------------------
module skp_timer
   import tx_symbols_pkg::*;
#(
   parameter int SKP_INTERVAL = 1180,
   parameter int CNT_W        = 11
) (
   input  logic clk,
   input  logic reset_L,
   input  logic skp_ack,
   output logic skp_req
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SKP_INTERVAL - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             pending_q;
   logic             pending_d;
   logic             expire;

   // Interval counter and request flag next-state. An expiry always leaves
   // the request set, even when it coincides with an acknowledge; that is
   // what produces a back-to-back SKP set instead of silently losing one.
   // Requests never stack: a second expiry while pending changes nothing.
   always_comb begin
      expire    = (count_q == CNT_LAST);
      count_d   = expire ? '0 : count_q + CNT_W'(1);
      pending_d = pending_q;
      if (expire) begin
         pending_d = 1'b1;
      end else if (skp_ack) begin
         pending_d = 1'b0;
      end
   end

   // Timer state registers
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         count_q   <= '0;
         pending_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         pending_q <= pending_d;
      end
   end

   assign skp_req = pending_q;

endmodule

// File: rtl/tx_framer.sv
// ---------------------------------------------------------------------------
// tx_framer
// Transmit framing sequencer. Brackets each packet pulled from the transmit
// buffer with STP/END, terminates a starved packet with EDB, inserts a
// COM + SKP_LEN x SKP ordered set at packet boundaries whenever the interval
// timer requests one, and fills every other cycle with logical idle.
//   clk      : transmit clock, all state on rising edge
//   reset_L  : asynchronous active-low reset
//   txBus    : tx_framer_if.master (buffer handshake + symbol-mux controls)
// ---------------------------------------------------------------------------
module tx_framer
   import tx_symbols_pkg::*;
#(
   parameter int SKP_INTERVAL = 1180,
   parameter int SKP_LEN      = 3,
   parameter int CNT_W        = 11
) (
   input logic         clk,
   input logic         reset_L,
   tx_framer_if.master txBus
);

   localparam int               IDX_W    = (SKP_LEN > 1) ? $clog2(SKP_LEN) : 1;
   localparam logic [IDX_W-1:0] SKP_LAST = IDX_W'(SKP_LEN - 1);

   txState_e         state_q;
   txState_e         state_d;
   logic [IDX_W-1:0] skpIdx_q;
   logic [IDX_W-1:0] skpIdx_d;
   logic             skpReq;
   logic             skpAck;
   logic             dataPop;
   logic [SEL_W-1:0] controlSel;
   logic [SYM_W-1:0] startEnd;
   logic [SYM_W-1:0] orderedSet;

   // Interval timer; it keeps running through packets so a request raised
   // mid-packet simply waits for the next boundary.
   skp_timer #(
      .SKP_INTERVAL (SKP_INTERVAL),
      .CNT_W        (CNT_W)
   ) u_skpTimer (
      .clk     (clk),
      .reset_L (reset_L),
      .skp_ack (skpAck),
      .skp_req (skpReq)
   );

   // Next-state logic. data_pop is only ever raised in DATA, and there it
   // follows data_avail directly so the mux samples the head byte in the
   // same cycle. A missing byte mid-packet ends the packet with EDB rather
   // than stalling the link. IDLE, END, EDB and the last SKP cycle all share
   // the same boundary decision.
   always_comb begin
      state_d  = state_q;
      skpIdx_d = skpIdx_q;
      dataPop  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            state_d = boundaryNext(skpReq, txBus.data_avail);
         end
         ST_STP: begin
            state_d = ST_DATA;
         end
         ST_DATA: begin
            if (txBus.data_avail) begin
               dataPop = 1'b1;
               if (txBus.data_last) begin
                  state_d = ST_END;
               end
            end else begin
               state_d = ST_EDB;
            end
         end
         ST_END, ST_EDB: begin
            state_d = boundaryNext(skpReq, txBus.data_avail);
         end
         ST_SKP_COM: begin
            state_d  = ST_SKP;
            skpIdx_d = '0;
         end
         ST_SKP: begin
            if (skpIdx_q == SKP_LAST) begin
               state_d = boundaryNext(skpReq, txBus.data_avail);
            end else begin
               skpIdx_d = skpIdx_q + IDX_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // The request is consumed on the edge that moves the framer into COM.
   // SKP_COM is never re-entered from itself, so this is a single-cycle ack.
   assign skpAck = (state_d == ST_SKP_COM) && (state_q != ST_SKP_COM);

   // State registers. An asynchronous reset abandons any packet in flight
   // without emitting END/EDB.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q  <= ST_IDLE;
         skpIdx_q <= '0;
      end else begin
         state_q  <= state_d;
         skpIdx_q <= skpIdx_d;
      end
   end

   // Mux controls decoded from the registered state only, so they are valid
   // for the whole cycle the state is held. Idle is the ordered-set default.
   always_comb begin
      controlSel = SEL_OS;
      startEnd   = 8'h00;
      orderedSet = SYM_IDL;
      case (state_q)
         ST_IDLE: begin
            controlSel = SEL_OS;
         end
         ST_STP: begin
            controlSel = SEL_SE;
            startEnd   = SYM_STP;
         end
         ST_DATA: begin
            controlSel = SEL_DATA;
         end
         ST_END: begin
            controlSel = SEL_SE;
            startEnd   = SYM_END;
         end
         ST_EDB: begin
            controlSel = SEL_SE;
            startEnd   = SYM_EDB;
         end
         ST_SKP_COM: begin
            controlSel = SEL_COM;
         end
         ST_SKP: begin
            controlSel = SEL_OS;
            orderedSet = SYM_SKP;
         end
         default: begin
            controlSel = SEL_OS;
         end
      endcase
   end

   assign txBus.data_pop    = dataPop;
   assign txBus.control     = controlSel;
   assign txBus.start_end   = startEnd;
   assign txBus.ordered_set = orderedSet;
   assign txBus.logical_COM = SYM_COM;
   assign txBus.underrun    = (state_q == ST_EDB);

endmodule

// File: tb/tb_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_tx_framer
// Self-checking bench for tx_framer with a short SKP interval (16). A packet
// buffer process answers data_pop, a symbol-stream model predicts the
// framer outputs each cycle, and directed sequences pin exact waveforms.
// ---------------------------------------------------------------------------
module tb_tx_framer;

   localparam int INTERVAL = 16;
   localparam int SKPLEN   = 3;

   logic clk     = 1'b0;
   logic reset_L = 1'b0;

   tx_framer_if bus();

   tx_framer #(
      .SKP_INTERVAL (INTERVAL),
      .SKP_LEN      (SKPLEN),
      .CNT_W        (5)
   ) dut (
      .clk     (clk),
      .reset_L (reset_L),
      .txBus   (bus.master)
   );

   always #5 clk = ~clk;

   int nChecks = 0;
   int nFails  = 0;

   // Comparison bookkeeping shared by every check in the bench
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
      nChecks++;
      if (actual !== required) begin
         nFails++;
         $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, actual, required, $time);
      end
   endtask

   task automatic checkSym(input string name, input logic [1:0] c,
                           input logic [7:0] se, input logic [7:0] os);
      checkOutput(name, {14'd0, bus.control, bus.start_end, bus.ordered_set},
                  {14'd0, c, se, os});
   endtask

   task automatic stepSym(input string name, input logic [1:0] c,
                          input logic [7:0] se, input logic [7:0] os);
      @(negedge clk);
      checkSym(name, c, se, os);
   endtask

   // Transmit buffer: a queue of packets, each with a length and an optional
   // byte count after which the buffer runs dry for one cycle and the rest
   // of that packet is discarded.
   int  pktLenQ[$];
   int  pktCutQ[$];
   int  curLen   = 0;
   int  curCut   = 0;
   int  popped   = 0;
   int  popTotal = 0;
   bit  active   = 1'b0;
   bit  starved  = 1'b0;
   bit  popSeen  = 1'b0;

   task automatic applyStimulus(input int len, input int cut);
      pktLenQ.push_back(len);
      pktCutQ.push_back(cut);
   endtask

   task automatic flushBuffer();
      pktLenQ.delete();
      pktCutQ.delete();
      active  = 1'b0;
      starved = 1'b0;
      popped  = 0;
      popSeen = 1'b0;
      bus.data_avail = 1'b0;
      bus.data_last  = 1'b0;
   endtask

   initial begin : bufferProc
      bus.data_avail = 1'b0;
      bus.data_last  = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (popSeen) popped++;
         popSeen = 1'b0;
         if (active) begin
            if (popped >= curLen) begin
               active = 1'b0;
            end else if (starved) begin
               active  = 1'b0;
               starved = 1'b0;
            end else if (curCut != 0 && popped == curCut) begin
               starved = 1'b1;
            end
         end
         if (!active && pktLenQ.size() > 0) begin
            curLen = pktLenQ.pop_front();
            curCut = pktCutQ.pop_front();
            popped = 0;
            active = 1'b1;
         end
         bus.data_avail = active && !starved;
         bus.data_last  = active && !starved && (popped == curLen - 1);
      end
   end

   initial begin : popMonitor
      forever begin
         @(negedge clk);
         if (bus.data_pop === 1'b1) begin
            popSeen = 1'b1;
            popTotal++;
         end
      end
   end

   // Symbol-stream model. expTok is the symbol on the wire this cycle:
   // I idle, S STP, D data, E END, B EDB, C COM, K SKP. Symbols that are
   // already committed (the data byte after STP, the SKPs after COM) wait in
   // a queue; otherwise the next symbol follows from packet/boundary rules.
   logic [7:0] expTok = "I";
   logic [7:0] pendQ[$];
   int         mCnt  = 0;
   bit         mPend = 1'b0;

   initial begin : modelProc
      bit         expiry;
      bit         ack;
      logic [7:0] nxt;
      forever begin
         @(posedge clk or negedge reset_L);
         if (!reset_L) begin
            expTok = "I";
            pendQ.delete();
            mCnt   = 0;
            mPend  = 1'b0;
         end else begin
            expiry = (mCnt == INTERVAL - 1);
            mCnt   = expiry ? 0 : mCnt + 1;
            ack    = 1'b0;
            if (pendQ.size() > 0) begin
               nxt = pendQ.pop_front();
            end else if (expTok == "D") begin
               nxt = !bus.data_avail ? "B" : (bus.data_last ? "E" : "D");
            end else if (mPend) begin
               nxt = "C";
               ack = 1'b1;
               for (int k = 0; k < SKPLEN; k++) pendQ.push_back("K");
            end else if (bus.data_avail) begin
               nxt = "S";
               pendQ.push_back("D");
            end else begin
               nxt = "I";
            end
            if (expiry) mPend = 1'b1;
            else if (ack) mPend = 1'b0;
            expTok = nxt;
         end
      end
   end

   function automatic logic [31:0] modelVec();
      logic [1:0] c;
      logic [7:0] se;
      logic [7:0] os;
      c  = 2'b10;
      se = 8'h00;
      os = 8'h7C;
      case (expTok)
         "S": begin c = 2'b01; se = 8'hFB; end
         "D": c = 2'b00;
         "E": begin c = 2'b01; se = 8'hFD; end
         "B": begin c = 2'b01; se = 8'hFE; end
         "C": c = 2'b11;
         "K": os = 8'h1C;
         default: ;
      endcase
      return {4'd0, c, se, os, 8'hBC, (expTok == "D") && bus.data_avail, expTok == "B"};
   endfunction

   function automatic logic [31:0] dutVec();
      return {4'd0, bus.control, bus.start_end, bus.ordered_set, bus.logical_COM,
              bus.data_pop, bus.underrun};
   endfunction

   // Cycle-by-cycle comparison against the model, mid-cycle
   initial begin : compareProc
      forever begin
         @(negedge clk);
         checkOutput("model_cycle", dutVec(), modelVec());
      end
   end

   task automatic waitForStp(input string name, input int budget);
      bit found;
      found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         if (bus.control == 2'b01 && bus.start_end == 8'hFB) found = 1'b1;
      end
      checkOutput({name, "_stp_seen"}, 32'(found), 32'd1);
   endtask

   task automatic doReset();
      @(posedge clk);
      #2;
      reset_L = 1'b0;
      flushBuffer();
      repeat (2) @(posedge clk);
      #2;
      reset_L = 1'b1;
   endtask

   initial begin : watchdog
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int p0;

      // Reset held with an empty buffer
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkSym("rst_hold", 2'b10, 8'h00, 8'h7C);
      checkOutput("rst_pop", 32'(bus.data_pop), 32'd0);
      checkOutput("rst_underrun", 32'(bus.underrun), 32'd0);
      checkOutput("rst_model_tok", 32'(expTok), 32'h49);
      @(posedge clk);
      #2;
      reset_L = 1'b1;

      // Idle link: SKP set after the 16th edge, repeating every 16 edges
      repeat (16) @(posedge clk);
      @(negedge clk);
      checkSym("idle_c16", 2'b10, 8'h00, 8'h7C);
      stepSym("skp_com_c17", 2'b11, 8'h00, 8'h7C);
      checkOutput("model_com_tok", 32'(expTok), 32'h43);
      for (int i = 0; i < SKPLEN; i++) stepSym("skp_sym", 2'b10, 8'h00, 8'h1C);
      stepSym("idle_after_skp", 2'b10, 8'h00, 8'h7C);
      repeat (11) @(negedge clk);
      stepSym("skp_com_c33", 2'b11, 8'h00, 8'h7C);

      // 4-byte packet queued during the SKP set goes out after it
      p0 = popTotal;
      applyStimulus(4, 0);
      waitForStp("pkt4", 10);
      checkOutput("model_stp_tok", 32'(expTok), 32'h53);
      for (int i = 0; i < 4; i++) stepSym("pkt4_data", 2'b00, 8'h00, 8'h7C);
      stepSym("pkt4_end", 2'b01, 8'hFD, 8'h7C);
      stepSym("pkt4_idle", 2'b10, 8'h00, 8'h7C);
      checkOutput("pkt4_pops", 32'(popTotal - p0), 32'd4);

      // 20-byte packet spanning two expiries: one SKP set after END, then
      // the queued 2-byte packet
      doReset();
      repeat (10) @(posedge clk);
      #2;
      p0 = popTotal;
      applyStimulus(20, 0);
      applyStimulus(2, 0);
      waitForStp("pkt20", 8);
      for (int i = 0; i < 20; i++) stepSym("pkt20_data", 2'b00, 8'h00, 8'h7C);
      stepSym("pkt20_end", 2'b01, 8'hFD, 8'h7C);
      checkOutput("pkt20_pops", 32'(popTotal - p0), 32'd20);
      stepSym("pkt20_com", 2'b11, 8'h00, 8'h7C);
      for (int i = 0; i < SKPLEN; i++) stepSym("pkt20_skp", 2'b10, 8'h00, 8'h1C);
      stepSym("pkt2_stp", 2'b01, 8'hFB, 8'h7C);
      stepSym("pkt2_d0", 2'b00, 8'h00, 8'h7C);
      stepSym("pkt2_d1", 2'b00, 8'h00, 8'h7C);
      stepSym("pkt2_end", 2'b01, 8'hFD, 8'h7C);
      stepSym("pkt2_idle", 2'b10, 8'h00, 8'h7C);

      // Buffer runs dry after byte 2 of 5: EDB with underrun, then a
      // one-byte packet
      doReset();
      applyStimulus(5, 2);
      applyStimulus(1, 0);
      waitForStp("cut", 6);
      stepSym("cut_d0", 2'b00, 8'h00, 8'h7C);
      stepSym("cut_d1", 2'b00, 8'h00, 8'h7C);
      stepSym("cut_dry", 2'b00, 8'h00, 8'h7C);
      checkOutput("cut_dry_pop", 32'(bus.data_pop), 32'd0);
      stepSym("cut_edb", 2'b01, 8'hFE, 8'h7C);
      checkOutput("cut_edb_underrun", 32'(bus.underrun), 32'd1);
      checkOutput("cut_edb_pop", 32'(bus.data_pop), 32'd0);
      stepSym("min_stp", 2'b01, 8'hFB, 8'h7C);
      checkOutput("min_stp_underrun", 32'(bus.underrun), 32'd0);
      stepSym("min_data", 2'b00, 8'h00, 8'h7C);
      stepSym("min_end", 2'b01, 8'hFD, 8'h7C);
      stepSym("min_idle", 2'b10, 8'h00, 8'h7C);

      // Asynchronous reset in the middle of a packet
      doReset();
      applyStimulus(6, 0);
      waitForStp("abort", 6);
      stepSym("abort_d0", 2'b00, 8'h00, 8'h7C);
      stepSym("abort_d1", 2'b00, 8'h00, 8'h7C);
      @(posedge clk);
      #2;
      reset_L = 1'b0;
      flushBuffer();
      #1;
      checkSym("async_rst", 2'b10, 8'h00, 8'h7C);
      checkOutput("async_rst_pop", 32'(bus.data_pop), 32'd0);
      repeat (2) @(posedge clk);
      #2;
      reset_L = 1'b1;
      applyStimulus(3, 0);
      waitForStp("after_rst", 6);
      for (int i = 0; i < 3; i++) stepSym("after_rst_data", 2'b00, 8'h00, 8'h7C);
      stepSym("after_rst_end", 2'b01, 8'hFD, 8'h7C);
      stepSym("after_rst_idle", 2'b10, 8'h00, 8'h7C);
      repeat (9) @(negedge clk);
      checkSym("after_rst_c16", 2'b10, 8'h00, 8'h7C);
      stepSym("after_rst_com_c17", 2'b11, 8'h00, 8'h7C);
      repeat (6) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
